// File: rtl/crc_arb_pkg.sv
// Shared types and helpers for the CRC frame arbiter: FSM states, widths and the
// round-robin search used by the requester picker.
package crc_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StClose,
        StHold
    } arb_state_e;

    localparam int unsigned CRC_W = 16;
    localparam logic [CRC_W-1:0] LEN_MAX = 16'hFFFF;

    // The search helper is sized for the largest supported requester count.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned MAX_IDW = 3;

    typedef logic [MAX_REQ-1:0] req_vec_t;
    typedef logic [MAX_IDW-1:0] max_idx_t;

    // First set bit of req strictly after ptr, wrapping modulo n. Offsets are walked from far
    // to near so the nearest candidate overwrites the others.
    function automatic max_idx_t rr_search(input req_vec_t req, input max_idx_t ptr,
                                           input int unsigned n);
        int unsigned cand;
        max_idx_t    pick;
        pick = ptr;
        for (int unsigned off = MAX_REQ; off >= 1; off--) begin
            if (off <= n) begin
                cand = (32'(ptr) + off) % n;
                if (req[cand[MAX_IDW-1:0]]) begin
                    pick = cand[MAX_IDW-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: selects the first requesting index above rr_ptr,
// wrapping, and flags whether any requester is active.
module rr_pick
    import crc_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    req_vec_t req_ext;
    max_idx_t pick;

    always_comb begin
        req_ext = req_vec_t'(req);
        pick    = rr_search(req_ext, max_idx_t'(rr_ptr), NREQ);
        idx     = pick[IDW-1:0];
        found   = |req;
    end

endmodule

// File: rtl/crc_frame_arbiter.sv
// Frame-level round-robin arbiter that streams one requester's frame at a time into a
// shared CRC-16 engine and returns the result through a valid/ready result register.
module crc_frame_arbiter
    import crc_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*CRC_W-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [CRC_W-1:0]      crc_data,
    output logic                  crc_valid,
    input  logic [CRC_W-1:0]      crc_result,
    input  logic                  crc_done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CRC_W-1:0]      res_crc,
    output logic [IDW-1:0]        res_id,
    output logic [CRC_W-1:0]      res_len,
    output logic                  res_err
);

    localparam logic [CRC_W-1:0] LEN_ONE = 1;

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CRC_W-1:0] len_q, len_d;
    logic [CRC_W-1:0] res_crc_q, res_crc_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic [CRC_W-1:0] res_len_q, res_len_d;
    logic             res_err_q, res_err_d;
    logic             res_valid_q, res_valid_d;

    logic [IDW-1:0]   pick_idx;
    logic             pick_found;
    logic             sel_valid;
    logic             sel_last;
    logic [CRC_W-1:0] sel_data;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        len_d       = len_q;
        res_crc_d   = res_crc_q;
        res_id_d    = res_id_q;
        res_len_d   = res_len_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        req_ready   = '0;
        crc_valid   = 1'b0;
        crc_data    = '0;
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_data    = '0;

        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*CRC_W +: CRC_W];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    len_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                crc_data  = sel_data;
                crc_valid = sel_valid;
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt_q == IDW'(i)) begin
                        req_ready[i] = sel_valid;
                    end
                end
                if (sel_valid) begin
                    if (len_q != LEN_MAX) begin
                        len_d = len_q + LEN_ONE;
                    end
                    if (sel_last) begin
                        state_d = StClose;
                    end
                end else begin
                    // Mid-frame bubble: the engine drops its state on its own, we only report.
                    res_crc_d   = '0;
                    res_id_d    = gnt_q;
                    res_len_d   = len_q;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    rr_ptr_d    = gnt_q;
                    state_d     = StHold;
                end
            end
            StClose: begin
                res_crc_d   = crc_result;
                res_id_d    = gnt_q;
                res_len_d   = len_q;
                res_err_d   = ~crc_done;
                res_valid_d = 1'b1;
                rr_ptr_d    = gnt_q;
                state_d     = StHold;
            end
            StHold: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            rr_ptr_q    <= IDW'(NREQ - 1);
            len_q       <= '0;
            res_crc_q   <= '0;
            res_id_q    <= '0;
            res_len_q   <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            len_q       <= len_d;
            res_crc_q   <= res_crc_d;
            res_id_q    <= res_id_d;
            res_len_q   <= res_len_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_crc   = res_crc_q;
    assign res_id    = res_id_q;
    assign res_len   = res_len_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Scoreboard bench for crc_frame_arbiter with a behavioural CRC engine, randomized frame
// rounds and a round-robin reference model.
module tb_crc_frame_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int MAXW = 32;

    logic                 clk_in;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_last;
    logic [NREQ*16-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [15:0]          crc_data;
    logic                 crc_valid;
    logic [15:0]          crc_result;
    logic                 crc_done;
    logic                 res_valid;
    logic                 res_ready;
    logic [15:0]          res_crc;
    logic [IDW-1:0]       res_id;
    logic [15:0]          res_len;
    logic                 res_err;

    crc_frame_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .crc_data   (crc_data),
        .crc_valid  (crc_valid),
        .crc_result (crc_result),
        .crc_done   (crc_done),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_crc    (res_crc),
        .res_id     (res_id),
        .res_len    (res_len),
        .res_err    (res_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Bit-serial CRC-16, poly 0x1021, MSB first.
    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] w);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int b = 15; b >= 0; b--) begin
            fb = r[15] ^ w[b];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    // Behavioural engine: accumulates while valid, clears when idle, pulses done on the
    // first idle cycle after a burst.
    logic [15:0] eng_crc;
    logic        eng_prev;
    logic        kill_done;
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            eng_crc  <= 16'h0;
            eng_prev <= 1'b0;
        end else begin
            eng_prev <= crc_valid;
            eng_crc  <= crc_valid ? crc_word(eng_crc, crc_data) : 16'h0;
        end
    end
    assign crc_result = eng_crc;
    assign crc_done   = eng_prev & ~crc_valid & ~kill_done;

    typedef struct {
        logic [15:0] crc;
        int          id;
        int          len;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    int          cmp_cnt = 0;
    int          bad_cnt = 0;
    logic [15:0] fw [NREQ][MAXW];
    int          flen [NREQ];
    int          fptr [NREQ];
    bit          fbub [NREQ];
    int          m_ptr;
    int          hold_cnt;
    bit          rand_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_frame(input int r);
        logic [15:0] c = 16'h0;
        for (int k = 0; k < flen[r]; k++) c = crc_word(c, fw[r][k]);
        return c;
    endfunction

    function automatic int rr_model(input bit [NREQ-1:0] set, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (set[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic load_frame(input int r, input int n, input bit bub);
        flen[r] = n;
        fptr[r] = 0;
        fbub[r] = bub;
        for (int k = 0; k < n; k++) fw[r][k] = 16'($urandom);
    endtask

    task automatic clear_frames();
        for (int i = 0; i < NREQ; i++) begin
            flen[i] = 0;
            fptr[i] = 0;
            fbub[i] = 1'b0;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (fptr[i] < flen[i]) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = !fbub[i] && (fptr[i] == flen[i] - 1);
                req_data[16*i +: 16] = fw[i][fptr[i]];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_data[16*i +: 16] = 16'h0;
            end
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk_in);
        acc = req_valid & req_ready;
        @(posedge clk_in);
        #1;
        for (int i = 0; i < NREQ; i++) if (acc[i]) fptr[i]++;
        if (hold_cnt > 0) begin
            res_ready = 1'b0;
            hold_cnt--;
        end else begin
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        drive_inputs();
    endtask

    // Predicts the grant order for frames that are all presented at once, pushes the
    // expected results, then runs until every result has been handed over.
    task automatic run_round(input bit [NREQ-1:0] mask, input bit lit0);
        bit [NREQ-1:0] left;
        exp_t          e;
        int            p;
        left = mask;
        while (left != 0) begin
            p     = rr_model(left, m_ptr);
            e.id  = p;
            e.len = flen[p];
            e.err = fbub[p] ? 1'b1 : kill_done;
            if (fbub[p])            e.crc = 16'h0000;
            else if (lit0 && p == 0) e.crc = 16'h1021;
            else                    e.crc = crc_frame(p);
            exp_q.push_back(e);
            left[p] = 1'b0;
            m_ptr   = p;
        end
        drive_inputs();
        for (int c = 0; c < 3000 && (exp_q.size() != 0 || res_valid); c++) step();
        chk("round_done", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_crc_valid"}, crc_valid, 0);
        chk({tag, "_crc_data"}, crc_data, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_crc"}, res_crc, 0);
        chk({tag, "_res_id"}, res_id, 0);
        chk({tag, "_res_len"}, res_len, 0);
        chk({tag, "_res_err"}, res_err, 0);
    endtask

    // Monitor: timing, burst shape and result contents against the scoreboard.
    initial begin
        int cyc = 0, last_acc = 0, cur_run = 0, last_run = 0;
        bit rv_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk_in);
            cyc++;
            if (rst) begin
                rv_prev  = 1'b0;
                cur_run  = 0;
                last_run = 0;
                last_acc = 0;
                continue;
            end
            if (|(req_valid & req_ready)) last_acc = cyc;
            if (crc_valid) cur_run++;
            else if (cur_run > 0) begin
                last_run = cur_run;
                cur_run  = 0;
            end
            if (res_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    cmp_cnt++;
                    bad_cnt++;
                    $display("FAIL unexpected_result: got id %0d, want no result", res_id);
                end else begin
                    chk("res_latency", cyc - last_acc, 2);
                    chk("burst_len", last_run, exp_q[0].len);
                end
            end
            if (res_valid) begin
                chk("hold_req_ready", req_ready, 0);
                chk("hold_crc_valid", crc_valid, 0);
            end
            if (res_valid && res_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("res_crc", res_crc, e.crc);
                chk("res_id", res_id, e.id);
                chk("res_len", res_len, e.len);
                chk("res_err", res_err, e.err);
            end
            rv_prev = res_valid;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [NREQ-1:0] mask;
        bit            bub;
        rst        = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        res_ready  = 1'b0;
        kill_done  = 1'b0;
        hold_cnt   = 0;
        rand_ready = 1'b0;
        m_ptr      = NREQ - 1;
        clear_frames();
        #12;
        check_reset_outputs("reset");
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        step();

        // Fairness from reset, then three-way contention with pointer at 2.
        load_frame(0, 2, 1'b0);
        load_frame(2, 3, 1'b0);
        run_round(4'b0101, 1'b0);
        load_frame(0, 1, 1'b0);
        load_frame(1, 2, 1'b0);
        load_frame(2, 4, 1'b0);
        run_round(4'b0111, 1'b0);

        // Single-word frame.
        load_frame(0, 1, 1'b0);
        fw[0][0] = 16'h0001;
        run_round(4'b0001, 1'b1);

        // Multi-word frame.
        load_frame(1, 3, 1'b0);
        fw[1][0] = 16'h0001;
        fw[1][1] = 16'h0000;
        fw[1][2] = 16'h1234;
        run_round(4'b0010, 1'b0);

        // Bubble after one word, then a clean frame.
        load_frame(3, 1, 1'b1);
        fw[3][0] = 16'hAAAA;
        run_round(4'b1000, 1'b0);
        load_frame(2, 3, 1'b0);
        run_round(4'b0100, 1'b0);

        // Engine fails to signal done.
        kill_done = 1'b1;
        load_frame(2, 2, 1'b0);
        run_round(4'b0100, 1'b0);
        kill_done = 1'b0;

        // Backpressure with a second requester waiting.
        hold_cnt = 25;
        load_frame(0, 2, 1'b0);
        load_frame(1, 3, 1'b0);
        run_round(4'b0011, 1'b0);

        // Randomized rounds.
        rand_ready = 1'b1;
        for (int r = 0; r < 40; r++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                if (mask[i]) begin
                    bub = ($urandom_range(0, 4) == 0);
                    load_frame(i, bub ? $urandom_range(1, 3) : $urandom_range(1, 6), bub);
                end
            end
            if ($urandom_range(0, 3) == 0) hold_cnt = $urandom_range(1, 12);
            run_round(mask, 1'b0);
        end
        rand_ready = 1'b0;

        // Reset in the middle of a 4-word frame.
        load_frame(0, 4, 1'b0);
        drive_inputs();
        for (int c = 0; c < 50 && fptr[0] < 2; c++) step();
        chk("midreset_progress", fptr[0], 2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        clear_frames();
        drive_inputs();
        exp_q.delete();
        m_ptr = NREQ - 1;
        step();
        step();
        rst = 1'b0;
        step();
        load_frame(0, 1, 1'b0);
        fw[0][0] = 16'h0001;
        load_frame(1, 2, 1'b0);
        load_frame(2, 1, 1'b0);
        load_frame(3, 3, 1'b0);
        run_round(4'b1111, 1'b1);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
